uart_tx_buffered: RTL
=====================

# uart_tx_buffered

Buffered UART transmitter for the board's serial link, the outbound counterpart to the receive path on `RsRx`. Bytes written by on-chip logic through a `data_in`/`we` strobe are queued in a small FIFO and serialized onto `RsTx` as 8N1 frames at a fixed baud rate. Baud timing comes from the system clock, and the line stays busy until the FIFO drains. The block sits between the character-producing logic and the top-level `RsTx` pin.

## Interface
- `CLK_FREQ`, 100_000_000, system clock frequency in Hz
- `BAUD`, 9600, line rate in bit/s; `BIT_CYCLES = CLK_FREQ/BAUD` (integer divide, ≥ 2)
- `DEPTH`, 16, FIFO depth in bytes; power of two, ≥ 2
- `clk`  in  1  system clock; all logic on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `data_in`  in  8  byte to enqueue
- `we`  in  1  write strobe, one byte per cycle while high
- `full`  out  1  FIFO holds `DEPTH` bytes
- `busy`  out  1  frame in progress or FIFO non-empty
- `overflow`  out  1  sticky: a write arrived while `full`
- `RsTx`  out  1  serial line, idle high, registered

## Operation
- Reset values: `RsTx`=1, `full`=0, `busy`=0, `overflow`=0, FIFO empty, state IDLE, counters 0.
- Write: on a posedge with `we`=1 and `full`=0, `data_in` is pushed. With `full`=1 the byte is dropped and `overflow` is set. `overflow` is cleared only by reset.
- A write while `full` is dropped even if a pop happens on the same edge.
- FIFO: read/write pointers of `$clog2(DEPTH)` bits wrap modulo `DEPTH`. Occupancy count is `$clog2(DEPTH)+1` bits wide.
- FSM states: IDLE, START, DATA, PARITY (only when compiled in), STOP.
  - IDLE: `RsTx`=1. If the FIFO is non-empty, pop into a shift register and go to START.
  - START: `RsTx`=0 for `BIT_CYCLES` cycles, then go to DATA.
  - DATA: drive shift[0], LSB first, with each bit held `BIT_CYCLES` cycles. A 3-bit index counts 0..7; after bit 7 go to PARITY or STOP.
  - STOP: `RsTx`=1 for `BIT_CYCLES` cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Bit timer: counter 0..`BIT_CYCLES`-1. It resets on every bit boundary and has `$clog2(BIT_CYCLES)` bits.
- `busy` = (state ≠ IDLE) | (count ≠ 0).
- Reset mid-frame: `RsTx` goes high immediately (async) and queued bytes are discarded.

## Timing
- Write accepted at edge N into an empty FIFO in IDLE:
  - pop at edge N+1
  - `RsTx` falls at edge N+1
  - first data bit at edge N+1+`BIT_CYCLES`
- Frame length: 10×`BIT_CYCLES` cycles, or 11×`BIT_CYCLES` with parity.
- `full` asserts the cycle after the push that makes count = `DEPTH`. It deasserts the cycle after the next pop.
- Back-to-back frames: the next start bit begins on the edge that ends the stop bit.

## Configuration
- `UART_TX_PARITY_EN` defined: an even-parity bit is inserted between bit 7 and STOP via the PARITY state. Parity bit = XOR of the 8 data bits, held `BIT_CYCLES` cycles.
- Not defined: no PARITY state and 8N1 framing only.

## Structure
- Package `uart_pkg`: the `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP) and the `UART_DATA_BITS`=8 constant. It is shared with the receiver.
- One sub-module, `sync_fifo`, parameterized by width and depth. It provides push/pop/full/empty/count. The FSM, bit timer and shift register stay in the top module.

## Test plan
Bench parameters: `CLK_FREQ`=1_000_000, `BAUD`=100_000, so `BIT_CYCLES`=10.
- Reset, no writes:
  - `RsTx`=1, `busy`=0 and `full`=0 for 200 cycles.
- Single write of 0x41:
  - `RsTx` = 0 (start), then 1,0,0,0,0,0,1,0, then 1 (stop), each level held for exactly 10 cycles.
  - Start bit begins one cycle after the write edge.
  - `busy` drops after 100 cycles.
- Burst write of 0x55, 0xAA, 0x0D on consecutive cycles:
  - Three contiguous 100-cycle frames with no idle between stop and start.
  - Decoded bytes match the written bytes in order.
- Overflow:
  - 18 consecutive writes with `DEPTH`=16: one pops immediately, 16 queue, `full`=1.
  - The 18th write is dropped and `overflow`=1.
  - 17 frames are transmitted, and `overflow` stays 1 afterwards.
- Reset mid-frame:
  - `rst_n` low during bit 3 of 0xFF → `RsTx`=1 in the same cycle.
  - After release: no further frames and `busy`=0.
- With `UART_TX_PARITY_EN`:
  - 0x07 → parity bit 1; 0x03 → parity bit 0.
  - Each frame is 110 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by both the transmit and receive paths.
//   tx_state_t     : transmitter FSM states (PARITY only reached when the
//                    transmitter is built with UART_TX_PARITY_EN)
//   UART_DATA_BITS : number of data bits per character
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with first-word fall-through read data.
// Parameters:
//   WIDTH : word width in bits
//   DEPTH : number of entries, power of two, >= 2
// Ports:
//   clk    in   clock, all logic on posedge
//   rst_n  in   asynchronous active-low reset (empties the FIFO)
//   push   in   write wdata this cycle (ignored while full)
//   wdata  in   word to write
//   pop    in   consume the head word this cycle (ignored while empty)
//   rdata  out  head word, valid while empty = 0
//   full   out  FIFO holds DEPTH words
//   empty  out  FIFO holds no words
//   count  out  current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is dropped even when a pop frees a slot on the
  // same edge, so the accept decision looks only at the registered full flag.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// uart_tx_buffered
// Buffered UART transmitter: bytes written with we/data_in are queued in a
// FIFO and sent on RsTx as 8N1 frames (8E1 when UART_TX_PARITY_EN is
// defined, adding an even-parity bit between bit 7 and the stop bit).
// Parameters:
//   CLK_FREQ : system clock in Hz
//   BAUD     : line rate in bit/s, CLK_FREQ/BAUD >= 2
//   DEPTH    : FIFO depth in bytes, power of two, >= 2
// Ports:
//   clk       in   system clock, all logic on posedge
//   rst_n     in   asynchronous active-low reset
//   data_in   in   byte to enqueue
//   we        in   write strobe, one byte per cycle while high
//   full      out  FIFO holds DEPTH bytes
//   busy      out  frame in progress or FIFO non-empty
//   overflow  out  sticky, set by a write while full, cleared by reset only
//   RsTx      out  registered serial line, idle high
// Build option: UART_TX_PARITY_EN
// ---------------------------------------------------------------------------
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int DEPTH    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       we,
  output logic       full,
  output logic       busy,
  output logic       overflow,
  output logic       RsTx
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int CW         = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

  tx_state_t                  state_q, state_d;
  logic [CW-1:0]              bit_cnt_q, bit_cnt_d;
  logic [2:0]                 bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
  logic                       tx_q, tx_d;
  logic                       overflow_q, overflow_d;
`ifdef UART_TX_PARITY_EN
  logic                       parity_q, parity_d;
`endif

  logic                       fifo_pop;
  logic [UART_DATA_BITS-1:0]  fifo_rdata;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [$clog2(DEPTH):0]     fifo_count;
  logic                       bit_end;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (we),
    .wdata (data_in),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bit_end = (bit_cnt_q == BIT_LAST);

  // tx_d is the line level for the state being entered, so RsTx changes on
  // the same edge as the state and stays a clean registered output.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_end ? '0 : bit_cnt_q + CW'(1);
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    fifo_pop   = 1'b0;
    overflow_d = overflow_q | (we & fifo_full);
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        tx_d      = 1'b1;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_rdata;
          bit_idx_d = '0;
          tx_d      = 1'b0;
          state_d   = START;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^fifo_rdata;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[UART_DATA_BITS-1:1]};
            tx_d      = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        // Chain straight into the next start bit when more bytes wait.
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            shift_d   = fifo_rdata;
            bit_idx_d = '0;
            tx_d      = 1'b0;
            state_d   = START;
`ifdef UART_TX_PARITY_EN
            parity_d  = ^fifo_rdata;
`endif
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        tx_d      = 1'b1;
        bit_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign RsTx     = tx_q;
  assign full     = fifo_full;
  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE) | (fifo_count != '0);

endmodule
